chad_cop: RTL and testbench

Multi-cycle arithmetic coprocessor for the chad core: the responder end of its coprocessor port. It starts an operation when the core issues a coprocessor instruction and runs iterative unsigned multiply and divide in the background. It requests core stalls only when the core issues another coprocessor instruction, or reads the result, while an operation is still running. Its `stall` output is ORed into the core's `hold`.

---
 rtl/chad_cop_pkg.sv | 17 +
 rtl/chad_cop.sv | 129 ++++++++++++
 tb/tb_chad_cop.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/chad_cop_pkg.sv
// Shared constants for the chad coprocessor: select codes, FSM encoding
// and the core opcode that reads the coprocessor result.
package chad_cop_pkg;

    localparam logic [2:0] COP_MUL  = 3'b000;
    localparam logic [2:0] COP_DIV  = 3'b001;
    localparam logic [2:0] COP_RDHI = 3'b010;
    localparam logic [2:0] COP_RDLO = 3'b011;
    localparam logic [2:0] COP_RDST = 3'b100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [6:0] COP_RD_OPCODE = 7'b0010000;

endpackage

// File: rtl/chad_cop.sv
// Iterative unsigned multiply/divide coprocessor for the chad core.
// Runs in the background and stalls the core only when it needs a result early.
module chad_cop
    import chad_cop_pkg::*;
#(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             hold,
    input  logic [15:0]      insn,
    input  logic             copgo,
    input  logic [WIDTH-1:0] copa,
    input  logic [WIDTH-1:0] copb,
    input  logic [WIDTH-1:0] copc,
    output logic [WIDTH-1:0] cop,
    output logic             stall,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    cnt;
    logic             ovf;

    logic             accept;
    logic             rdcop;
    logic [2:0]       sel;
    logic             sub;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH+1:0] add_s;
    logic [WIDTH:0]   hsum;
    logic             geq;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    assign busy   = (state != ST_IDLE);
    assign rdcop  = (insn[15:9] == COP_RD_OPCODE);
    assign stall  = busy & (copgo | rdcop);
    assign sel    = insn[2:0];
    assign accept = copgo & ~hold & ~busy;

    // One WIDTH+1-bit adder: adds MCAND for MUL, subtracts DVSR for DIV.
    // For subtraction the extra top bit of add_s is the no-borrow flag (r >= DVSR).
    assign sub    = (state == ST_DIV);
    assign rem_sh = {hi, lo[WIDTH-1]};
    assign add_a  = sub ? rem_sh : {1'b0, hi};
    assign add_b  = {1'b0, opnd} ^ {(WIDTH + 1){sub}};
    assign add_s  = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH + 1){1'b0}}, sub};
    assign geq    = add_s[WIDTH+1];

    always_comb begin
        hsum = '0;
        hi_n = hi;
        lo_n = lo;
        if (sub) begin
            hi_n = geq ? add_s[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], geq};
        end else begin
            hsum = lo[0] ? add_s[WIDTH:0] : {1'b0, hi};
            hi_n = hsum[WIDTH:1];
            lo_n = {hsum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state <= ST_IDLE;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            cop   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (sel)
                            COP_MUL: begin
                                lo    <= copa;
                                hi    <= '0;
                                opnd  <= copb;
                                cnt   <= CW'(WIDTH);
                                state <= ST_MUL;
                            end
                            COP_DIV: begin
                                if (copc >= copa) begin
                                    hi  <= '1;
                                    lo  <= '1;
                                    cop <= '1;
                                    ovf <= 1'b1;
                                end else begin
                                    ovf   <= 1'b0;
                                    hi    <= copc;
                                    lo    <= copb;
                                    opnd  <= copa;
                                    cnt   <= CW'(WIDTH);
                                    state <= ST_DIV;
                                end
                            end
                            COP_RDHI: cop <= hi;
                            COP_RDLO: cop <= lo;
                            COP_RDST: cop <= {{(WIDTH - 1){1'b0}}, ovf};
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_IDLE;
                        cop   <= lo_n;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chad_cop.sv
// Directed self-checking bench for chad_cop with WIDTH = 18.
module tb_chad_cop;

    localparam int unsigned W = 18;

    logic         clk    = 1'b0;
    logic         resetq = 1'b0;
    logic         hold   = 1'b0;
    logic         copgo  = 1'b0;
    logic [15:0]  insn   = '0;
    logic [W-1:0] copa   = '0;
    logic [W-1:0] copb   = '0;
    logic [W-1:0] copc   = '0;
    logic [W-1:0] cop;
    logic         stall;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int n;

    chad_cop #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetq (resetq),
        .hold   (hold),
        .insn   (insn),
        .copgo  (copgo),
        .copa   (copa),
        .copb   (copb),
        .copc   (copc),
        .cop    (cop),
        .stall  (stall),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] sel, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c);
        insn  = {13'b0, sel};
        copa  = a;
        copb  = b;
        copc  = c;
        copgo = 1'b1;
        step();
        copgo = 1'b0;
        insn  = '0;
    endtask

    task automatic run_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        check("reset_cop", 32'(cop), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        resetq = 1'b1;
        step();

        // MUL 3 x 5
        issue(3'b000, 18'd3, 18'd5, 18'd0);
        check("mul_busy_e0", 32'(busy), 32'h1);
        run_busy(n);
        check("mul_busy_cycles", 32'(n), 32'd18);
        check("mul_3x5_cop", 32'(cop), 32'd15);
        issue(3'b010, '0, '0, '0);
        check("mul_3x5_hi", 32'(cop), 32'h0);

        // MUL max x max
        issue(3'b000, 18'h3FFFF, 18'h3FFFF, 18'd0);
        run_busy(n);
        check("mul_max_cop", 32'(cop), 32'h1);
        issue(3'b011, '0, '0, '0);
        check("mul_max_lo", 32'(cop), 32'h1);
        issue(3'b010, '0, '0, '0);
        check("mul_max_hi", 32'(cop), 32'h3FFFE);

        // DIV 100 / 7
        issue(3'b001, 18'd7, 18'd100, 18'd0);
        check("div_busy_e0", 32'(busy), 32'h1);
        run_busy(n);
        check("div_busy_cycles", 32'(n), 32'd18);
        check("div_quot", 32'(cop), 32'd14);
        issue(3'b010, '0, '0, '0);
        check("div_rem", 32'(cop), 32'd2);
        issue(3'b100, '0, '0, '0);
        check("div_ovf0", 32'(cop), 32'h0);

        // reserved select leaves everything alone
        issue(3'b011, '0, '0, '0);
        check("rdlo_pre_noop", 32'(cop), 32'd14);
        issue(3'b101, 18'd1, 18'd1, 18'd1);
        check("noop_busy", 32'(busy), 32'h0);
        check("noop_cop", 32'(cop), 32'd14);
        issue(3'b010, '0, '0, '0);
        check("noop_hi", 32'(cop), 32'd2);

        // DIV overflow: T == 0, then W == T after a clean DIV
        issue(3'b001, 18'd0, 18'd9, 18'd0);
        check("div0_busy", 32'(busy), 32'h0);
        issue(3'b010, '0, '0, '0);
        check("div0_hi", 32'(cop), 32'h3FFFF);
        issue(3'b011, '0, '0, '0);
        check("div0_lo", 32'(cop), 32'h3FFFF);
        issue(3'b100, '0, '0, '0);
        check("div0_ovf", 32'(cop), 32'h1);
        issue(3'b001, 18'd7, 18'd100, 18'd0);
        run_busy(n);
        issue(3'b100, '0, '0, '0);
        check("div_ovf_cleared", 32'(cop), 32'h0);
        issue(3'b001, 18'd5, 18'd3, 18'd5);
        check("divwt_busy", 32'(busy), 32'h0);
        issue(3'b011, '0, '0, '0);
        check("divwt_lo", 32'(cop), 32'h3FFFF);
        issue(3'b100, '0, '0, '0);
        check("divwt_ovf", 32'(cop), 32'h1);

        // stall on a second copgo plus COP read while a MUL runs, hold pulses throughout
        issue(3'b000, 18'd3, 18'd5, 18'd0);
        step();
        step();
        step();
        copa  = 18'd6;
        copb  = 18'd7;
        insn  = 16'h2000;
        copgo = 1'b1;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            check("stall_while_busy", 32'(stall), 32'h1);
            hold = (n % 4 == 2);
            n++;
            step();
        end
        hold = 1'b0;
        check("stall_busy_left", 32'(n), 32'd15);
        check("stall_released", 32'(stall), 32'h0);
        check("first_mul_cop", 32'(cop), 32'd15);
        step();
        copgo = 1'b0;
        insn  = '0;
        check("second_busy_e0", 32'(busy), 32'h1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            hold = (n % 5 == 3);
            n++;
            step();
        end
        hold = 1'b0;
        check("second_busy_cycles", 32'(n), 32'd18);
        check("second_mul_cop", 32'(cop), 32'd42);

        // copgo held across held cycles is accepted on the hold-low edge
        hold  = 1'b1;
        copgo = 1'b1;
        insn  = {13'b0, 3'b010};
        step();
        step();
        step();
        check("held_no_accept", 32'(cop), 32'd42);
        hold = 1'b0;
        step();
        copgo = 1'b0;
        insn  = '0;
        check("held_accept", 32'(cop), 32'h0);

        // asynchronous reset in the middle of a DIV
        issue(3'b011, '0, '0, '0);
        check("pre_reset_cop", 32'(cop), 32'd42);
        issue(3'b001, 18'd7, 18'd100, 18'd0);
        repeat (9) step();
        copgo = 1'b1;
        insn  = 16'h2000;
        #1;
        check("pre_reset_stall", 32'(stall), 32'h1);
        resetq = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'h0);
        check("async_stall", 32'(stall), 32'h0);
        check("async_cop", 32'(cop), 32'h0);
        copgo = 1'b0;
        insn  = '0;
        step();
        resetq = 1'b1;
        step();
        issue(3'b000, 18'd2, 18'd2, 18'd0);
        run_busy(n);
        check("post_reset_busy_cycles", 32'(n), 32'd18);
        check("post_reset_mul", 32'(cop), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
